// File: rtl/fifo_word_packer_if.sv
// Handshake bundle between the byte shift line, the word packer and the word consumer.
// The slave view belongs to the packer; the master view belongs to whoever drives the packer.
interface fifo_word_packer_if;
  logic        EN;
  logic [7:0]  IN_DATA;
  logic        IN_READY;
  logic        FLUSH;
  logic [31:0] OUT_DATA;
  logic [2:0]  OUT_NBYTES;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        PRIMED;
  logic        OVERFLOW;

  modport master (
    output EN, IN_DATA, FLUSH, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_NBYTES, OUT_VALID, PRIMED, OVERFLOW
  );

  modport slave (
    input  EN, IN_DATA, FLUSH, OUT_READY,
    output IN_READY, OUT_DATA, OUT_NBYTES, OUT_VALID, PRIMED, OVERFLOW
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Packs bytes leaving a DEPTH-stage shift line into 32-bit words behind a 2-entry buffer.
// Bytes are only taken once the line is primed, one cycle after the EN that exposed them.
module fifo_word_packer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                CLK,
  input  logic                RST,
  fifo_word_packer_if.slave   bus
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_d_q, en_d_d;
  logic [31:0]      asm_q, asm_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      buf_data_q [0:1];
  logic [31:0]      buf_data_d [0:1];
  logic [2:0]       buf_nb_q [0:1];
  logic [2:0]       buf_nb_d [0:1];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             flush_pend_q, flush_pend_d;
  logic             ovf_q, ovf_d;

  logic             primed_s;
  logic             sample_s;
  logic             pop_s;
  logic             space_s;
  logic             flush_req_s;
  logic             push_s;
  logic             push_ok_s;
  logic [31:0]      asm_new_s;
  logic [2:0]       idx_new_s;

  assign primed_s    = (cnt_q == DEPTH_C);
  assign sample_s    = en_d_q && primed_s;
  assign pop_s       = (count_q != 2'd0) && bus.OUT_READY;
  assign space_s     = (count_q < 2'd2) || pop_s;
  assign flush_req_s = bus.FLUSH || flush_pend_q;

  assign bus.OUT_VALID  = (count_q != 2'd0);
  assign bus.OUT_DATA   = (count_q != 2'd0) ? buf_data_q[rd_ptr_q] : 32'd0;
  assign bus.OUT_NBYTES = (count_q != 2'd0) ? buf_nb_q[rd_ptr_q] : 3'd0;
  assign bus.IN_READY   = (count_q < 2'd2) && !flush_pend_q;
  assign bus.PRIMED     = primed_s;
  assign bus.OVERFLOW   = ovf_q;

  // Next-state: priming, lane assembly, push/flush/overflow decision and buffer bookkeeping.
  always_comb begin
    cnt_d        = cnt_q;
    en_d_d       = bus.EN;
    asm_d        = asm_q;
    idx_d        = idx_q;
    buf_data_d   = buf_data_q;
    buf_nb_d     = buf_nb_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    flush_pend_d = flush_pend_q;
    ovf_d        = ovf_q;
    asm_new_s    = asm_q;
    idx_new_s    = idx_q;
    push_s       = 1'b0;
    push_ok_s    = 1'b0;

    if (bus.EN && !primed_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (sample_s) begin
      asm_new_s[{idx_q[1:0], 3'b000} +: 8] = bus.IN_DATA;
      idx_new_s = idx_q + 3'd1;
    end else begin
      asm_new_s = asm_q;
      idx_new_s = idx_q;
    end

    // A completed word always pushes; a flush pushes only if something is assembled.
    if (idx_new_s == 3'd4) begin
      push_s = 1'b1;
    end else if (flush_req_s && (idx_new_s != 3'd0)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end

    asm_d = asm_new_s;
    idx_d = idx_new_s;
    if (push_s) begin
      if (space_s) begin
        push_ok_s            = 1'b1;
        buf_data_d[wr_ptr_q] = asm_new_s;
        buf_nb_d[wr_ptr_q]   = idx_new_s;
        wr_ptr_d             = ~wr_ptr_q;
        asm_d                = 32'd0;
        idx_d                = 3'd0;
        flush_pend_d         = 1'b0;
      end else if (idx_new_s == 3'd4) begin
        asm_d        = 32'd0;
        idx_d        = 3'd0;
        ovf_d        = 1'b1;
        flush_pend_d = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end else begin
      flush_pend_d = 1'b0;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q         <= '0;
      en_d_q        <= 1'b0;
      asm_q         <= 32'd0;
      idx_q         <= 3'd0;
      buf_data_q[0] <= 32'd0;
      buf_data_q[1] <= 32'd0;
      buf_nb_q[0]   <= 3'd0;
      buf_nb_q[1]   <= 3'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      flush_pend_q  <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      en_d_q        <= en_d_d;
      asm_q         <= asm_d;
      idx_q         <= idx_d;
      buf_data_q[0] <= buf_data_d[0];
      buf_data_q[1] <= buf_data_d[1];
      buf_nb_q[0]   <= buf_nb_d[0];
      buf_nb_q[1]   <= buf_nb_d[1];
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      flush_pend_q  <= flush_pend_d;
      ovf_q         <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: models the upstream 8-stage shift line, queues hand-computed
// words and lets a negedge monitor pop and compare every word the packer hands out.
module tb_fifo_word_packer;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  nb;
  } word_t;

  logic        clk;
  logic        rst;
  logic [7:0]  new_byte;
  logic [7:0]  line_q [0:7];
  word_t       exp_q [$];
  int          checks;
  int          errors;

  fifo_word_packer_if bus ();

  fifo_word_packer #(.DEPTH(8), .CNT_W(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream shift line: cleared together with the packer, shifts on EN.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) line_q[i] <= 8'd0;
    end else if (bus.EN) begin
      line_q[0] <= new_byte;
      for (int i = 1; i < 8; i++) line_q[i] <= line_q[i-1];
    end
  end
  assign bus.IN_DATA = line_q[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [2:0] n);
    word_t w;
    w.data = d;
    w.nb   = n;
    exp_q.push_back(w);
  endtask

  task automatic cyc(input logic en, input logic [7:0] b, input logic fl);
    bus.EN    = en;
    new_byte  = b;
    bus.FLUSH = fl;
    @(posedge clk);
    #1;
    bus.EN    = 1'b0;
    bus.FLUSH = 1'b0;
  endtask

  task automatic wait_ready(input int max_cycles);
    int n;
    n = 0;
    while (!bus.IN_READY && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_ready", {31'd0, bus.IN_READY}, 32'd1);
  endtask

  // Scoreboard monitor: every accepted word must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && bus.OUT_VALID && bus.OUT_READY) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", bus.OUT_DATA, 32'hFFFF_FFFF);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        chk("word_data", bus.OUT_DATA, w.data);
        chk("word_nbytes", {29'd0, bus.OUT_NBYTES}, {29'd0, w.nb});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    bus.EN = 1'b0;
    bus.FLUSH = 1'b0;
    bus.OUT_READY = 1'b1;
    new_byte = 8'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid",   {31'd0, bus.OUT_VALID}, 32'd0);
    chk("rst_data",    bus.OUT_DATA, 32'd0);
    chk("rst_nbytes",  {29'd0, bus.OUT_NBYTES}, 32'd0);
    chk("rst_primed",  {31'd0, bus.PRIMED}, 32'd0);
    chk("rst_ovf",     {31'd0, bus.OVERFLOW}, 32'd0);
    chk("rst_ready",   {31'd0, bus.IN_READY}, 32'd1);

    // Priming and the first word.
    expect_word(32'h0403_0201, 3'd4);
    for (int i = 1; i <= 11; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 7) chk("t1_primed_7", {31'd0, bus.PRIMED}, 32'd0);
      if (i == 8) chk("t1_primed_8", {31'd0, bus.PRIMED}, 32'd1);
    end
    chk("t1_valid_e11", {31'd0, bus.OUT_VALID}, 32'd0);
    cyc(1'b0, 8'd0, 1'b0);
    chk("t1_valid_on", {31'd0, bus.OUT_VALID}, 32'd1);
    cyc(1'b0, 8'd0, 1'b0);
    chk("t1_valid_off", {31'd0, bus.OUT_VALID}, 32'd0);

    // Partial word via FLUSH; a second FLUSH with nothing assembled is ignored.
    rst = 1'b1;
    cyc(1'b0, 8'd0, 1'b0);
    rst = 1'b0;
    expect_word(32'h0000_BBAA, 3'd2);
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0);
    for (int k = 0; k < 7; k++) cyc(1'b1, 8'h10 + 8'(k), 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1);
    chk("t2_valid", {31'd0, bus.OUT_VALID}, 32'd1);
    cyc(1'b0, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1);
    cyc(1'b0, 8'd0, 1'b0);
    chk("t2_no_word", {31'd0, bus.OUT_VALID}, 32'd0);

    // Back-pressure: exposed bytes are 10..16 then 20.., consumer stalled.
    expect_word(32'h1312_1110, 3'd4);
    expect_word(32'h2016_1514, 3'd4);
    expect_word(32'h2423_2221, 3'd4);
    bus.OUT_READY = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b1, 8'h1F + 8'(k), 1'b0);
      if (k == 8) chk("t3_ready_8", {31'd0, bus.IN_READY}, 32'd1);
    end
    chk("t3_ready_9", {31'd0, bus.IN_READY}, 32'd0);
    cyc(1'b0, 8'd0, 1'b0);
    chk("t3_head", bus.OUT_DATA, 32'h1312_1110);
    chk("t3_ready_stall", {31'd0, bus.IN_READY}, 32'd0);
    chk("t3_ovf", {31'd0, bus.OVERFLOW}, 32'd0);
    bus.OUT_READY = 1'b1;
    for (int k = 10; k <= 12; k++) begin
      wait_ready(8);
      cyc(1'b1, 8'h1F + 8'(k), 1'b0);
    end
    repeat (3) cyc(1'b0, 8'd0, 1'b0);
    chk("t3_ovf_end", {31'd0, bus.OVERFLOW}, 32'd0);
    chk("t3_drained", {31'd0, bus.OUT_VALID}, 32'd0);

    // Forced EN into a full buffer: third word 34333231 is dropped.
    expect_word(32'h2827_2625, 3'd4);
    expect_word(32'h302B_2A29, 3'd4);
    bus.OUT_READY = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 8'h30 + 8'(k), 1'b0);
      if (k == 11) chk("t4_ovf_pre", {31'd0, bus.OVERFLOW}, 32'd0);
    end
    cyc(1'b0, 8'd0, 1'b0);
    chk("t4_ovf", {31'd0, bus.OVERFLOW}, 32'd1);
    chk("t4_ready", {31'd0, bus.IN_READY}, 32'd0);
    bus.OUT_READY = 1'b1;
    repeat (3) cyc(1'b0, 8'd0, 1'b0);
    chk("t4_ovf_sticky", {31'd0, bus.OVERFLOW}, 32'd1);
    chk("t4_drained", {31'd0, bus.OUT_VALID}, 32'd0);

    // FLUSH coinciding with the fourth sample yields exactly one full word.
    expect_word(32'h3837_3635, 3'd4);
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'h40 + 8'(k), 1'b0);
    cyc(1'b0, 8'd0, 1'b1);
    chk("t5_valid", {31'd0, bus.OUT_VALID}, 32'd1);
    chk("t5_nbytes", {29'd0, bus.OUT_NBYTES}, 32'd4);
    repeat (3) cyc(1'b0, 8'd0, 1'b0);
    chk("t5_no_extra", {31'd0, bus.OUT_VALID}, 32'd0);

    // Reset mid-operation discards the buffered word and the two assembled bytes.
    bus.OUT_READY = 1'b0;
    for (int k = 0; k < 6; k++) cyc(1'b1, 8'h50 + 8'(k), 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    chk("t6_pre_valid", {31'd0, bus.OUT_VALID}, 32'd1);
    rst = 1'b1;
    cyc(1'b0, 8'd0, 1'b0);
    rst = 1'b0;
    chk("t6_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("t6_data", bus.OUT_DATA, 32'd0);
    chk("t6_primed", {31'd0, bus.PRIMED}, 32'd0);
    chk("t6_ovf", {31'd0, bus.OVERFLOW}, 32'd0);
    chk("t6_ready", {31'd0, bus.IN_READY}, 32'd1);
    bus.OUT_READY = 1'b1;
    expect_word(32'h6362_6160, 3'd4);
    for (int k = 0; k < 11; k++) begin
      cyc(1'b1, 8'h60 + 8'(k), 1'b0);
      if (k == 6) chk("t6_primed_7", {31'd0, bus.PRIMED}, 32'd0);
      if (k == 7) chk("t6_primed_8", {31'd0, bus.PRIMED}, 32'd1);
      if (k == 9) chk("t6_no_word", {31'd0, bus.OUT_VALID}, 32'd0);
    end
    cyc(1'b0, 8'd0, 1'b0);
    chk("t6_word_valid", {31'd0, bus.OUT_VALID}, 32'd1);
    repeat (2) cyc(1'b0, 8'd0, 1'b0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
Downstream consumer of the 8-stage byte shift-line FIFO. It watches the shift line's EN strobe and tracks priming, so it knows when the shift line's output byte is valid. It then samples that byte one cycle after each qualifying EN and packs four bytes into a 32-bit word. Words are presented on a valid/ready interface through a 2-entry output buffer. IN_READY is back-pressure to whoever drives EN.

Parameters:
DEPTH, 8, shift-line depth; number of EN pulses after reset before the shift-line output carries real data.
CNT_W, 4, width of the priming counter; must satisfy 2^CNT_W > DEPTH.

Ports:
CLK  input  1  clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset. Must be asserted whenever the upstream shift line is cleared.
EN  input  1  the same shift strobe driving the shift line; one byte enters the line per cycle EN=1.
IN_DATA  input  8  the shift line's 8-bit output (OUT_W).
IN_READY  output  1  upstream may assert EN only while IN_READY=1.
FLUSH  input  1  single-cycle pulse; emit the partial word now.
OUT_DATA  output  32  packed word; first byte in [7:0], fourth in [31:24].
OUT_NBYTES  output  3  valid bytes in OUT_DATA, 1..4; unused upper bytes are 0.
OUT_VALID  output  1  buffer head holds a word.
OUT_READY  input  1  consumer accepts the word when OUT_VALID and OUT_READY are both 1.
PRIMED  output  1  priming count has reached DEPTH.
OVERFLOW  output  1  sticky; a byte was dropped because storage was full.

Behaviour:
- Reset (RST=1 at an edge): outputs go to OUT_VALID=0, OUT_DATA=0, OUT_NBYTES=0, PRIMED=0, OVERFLOW=0, IN_READY=1.
  - Priming counter, assembly register, byte index, EN delay flop, buffer pointers/count and flush-pending flag all clear.
  - RST overrides every other input; mid-operation it discards buffered words and partial bytes.
- Priming counter: increments on each EN=1 edge and saturates at DEPTH. PRIMED = (count == DEPTH).
- EN delay flop: en_d <= EN every cycle.
- Sampling: a byte is taken when en_d=1 and PRIMED=1, using the counter value already updated at the EN edge.
  - Consequence: the byte shifted in by the 1st EN is sampled in the cycle after the DEPTH-th EN.
  - Latency: one cycle from an EN edge to the sample edge.
- Assembly: the sampled byte goes into lane idx (0..3) and idx increments.
  - When idx was 3, the word is pushed to the buffer with NBYTES=4, and the assembly register and idx clear (idx wraps 3->0).
- Output buffer: 2-entry circular buffer.
  - OUT_* show the head entry; OUT_DATA and OUT_NBYTES are 0 when the buffer is empty.
  - A pop happens when OUT_VALID and OUT_READY are both 1.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
  - OUT_VALID=1 whenever the count is nonzero.
- IN_READY = (count < 2) and not flush_pending; combinational from registered state.
  - This guarantees space for the one in-flight byte allowed by the one-cycle sample latency.
- Overflow: if a push is required while count==2 and there is no pop that cycle, the word is dropped and OVERFLOW is set.
  - OVERFLOW is sticky until RST.
  - An EN issued while IN_READY=0 whose byte must be stored but cannot is also an overflow.
- FLUSH handling:
  - FLUSH with idx==0 and no byte sampled that cycle: ignored.
  - Otherwise, the partial word (including any byte sampled the same cycle) is pushed with NBYTES=idx (after the add), zero-padded, and idx clears.
  - If a sample that cycle completes 4 bytes, exactly one word is pushed with NBYTES=4; the FLUSH is consumed.
  - If the buffer is full without a pop, flush_pending is set. The flush executes on the first cycle with space and clears flush_pending.
  - Bytes sampled while flush_pending are appended first.
- Priming is never reset by FLUSH. Only RST re-primes.

Test Plan:
- RST, then 11 EN pulses with shift-line input 0x01..0x0B, OUT_READY=1 -> PRIMED rises after the 8th EN; one word 0x04030201 with NBYTES=4; OUT_VALID is 1 for exactly one cycle, 2 cycles after the 11th EN.
- Primed line, 2 EN pulses (bytes 0xAA, 0xBB), then FLUSH -> word 0x0000BBAA with NBYTES=2; a second FLUSH with idx=0 produces nothing.
- OUT_READY=0 with 12 continuous bytes after priming -> two words are buffered, IN_READY drops the cycle after the second push, and the in-flight byte lands in lane 0. When OUT_READY=1, words drain in order and IN_READY returns. OVERFLOW stays 0.
- Buffer full with EN forced despite IN_READY=0 until a third word completes -> the word is dropped and OVERFLOW=1 until RST.
- FLUSH in the same cycle as the 4th-byte sample -> exactly one word with NBYTES=4; no empty word follows.
- RST asserted with 1 word buffered and 2 bytes assembled -> next cycle OUT_VALID=0, PRIMED=0, OVERFLOW=0; DEPTH more EN pulses are needed before sampling resumes.
